ntwrk_size_tracker: RTL and testbench
=====================================

// Module: ntwrk_size_tracker
// PURPOSE
// Parametrised network-size engine for the junction-box circuit solver. Consumes
// ntwrk_size_cmd_t commands from the union/remap stage and keeps a live size per
// network ID. Answers single-network LOOKUPs and, on UPDATE, scans all networks to
// report the product of the TOP_K largest sizes (TOP_K is generic; it was fixed at 3).
// PARAMETERS
// NUM_CONNS  `NUM_CONNS               number of network IDs (table depth)
// SIZE_W     $clog2(NUM_POINTS)+1     width of one network size
// TOP_K      3                        largest networks multiplied on UPDATE (1..8)
// PROD_W     SIZE_W*TOP_K             width of product result
// PORTS
// clk         in   1                  clock
// rst         in   1                  asynchronous reset, active-high
// cmd_vld     in   1                  command valid
// cmd_rdy     out  1                  engine ready for a command
// cmd         in   ntwrk_size_cmd_t   {ntwrkb, ntwrka, cmd id}
// rsp_vld     out  1                  response valid
// rsp_rdy     in   1                  response accepted
// rsp_data    out  PROD_W             LOOKUP size (zero-extended) or top-K product
// rsp_is_prod out  1                  1 = UPDATE product, 0 = LOOKUP size
// busy        out  1                  FSM not in IDLE
// err         out  1                  sticky error flag, cleared only by rst
// BEHAVIOUR
// - Reset (async, any state): size[] = 0, valid[] = 0, FSM = IDLE, cmd_rdy = 1,
//   rsp_vld = 0, rsp_data = 0, rsp_is_prod = 0, busy = 0, err = 0.
// - Table: register array, NUM_CONNS x (valid, size); single-cycle read-modify-write.
// - A command is accepted on cmd_vld & cmd_rdy. cmd_rdy = 1 only in IDLE.
// - FSM states: IDLE, MERGE, SCAN, MULT, RESP.
// - NEW:    size[a] <= 2, valid[a] <= 1. If valid[a] was already 1, err <= 1. Stays IDLE.
// - WR_A:   size[a] += 1. WR_B: size[b] += 1. Target invalid -> err <= 1, no write.
// - MERGE:  IDLE -> MERGE. Next cycle size[a] += size[b], valid[b] <= 0, size[b] <= 0.
//   Then back to IDLE (2-cycle occupancy).
//   a == b -> behaves as IGNORE. Either side invalid -> err <= 1, no write.
// - IGNORE: no state change. Cmd ids 3'b111 are treated as IGNORE and set err.
// - LOOKUP: rsp_data <= size[a] (0 if invalid), rsp_is_prod <= 0, goto RESP next cycle.
// - UPDATE: goto SCAN. Index i = 0..NUM_CONNS-1, one entry per cycle.
//   - Valid entries are inserted into a descending top-K register list.
//   - On a tie, the earlier entry stays ahead.
//   - Then goto MULT: K-1 cycles, one multiply per cycle into a PROD_W accumulator.
//   - Then goto RESP with rsp_is_prod <= 1.
//   - Total latency from accept to rsp_vld: NUM_CONNS + TOP_K cycles.
// - Fewer than TOP_K valid networks: missing slots count as 1. No valid networks -> 1.
// - Size arithmetic saturates at 2^SIZE_W-1 and sets err. Product is exact by PROD_W.
// - RESP: rsp_vld = 1, rsp_data and rsp_is_prod held stable until rsp_rdy.
//   Then goto IDLE the next cycle. No command is accepted while rsp_vld = 1.
// - A command is visible to a LOOKUP/UPDATE issued on the next accepted cycle
//   (read-after-write ordering).
// - busy = (state != IDLE). err never clears except by rst.
// TESTING
// 1. rst mid-SCAN -> next cycle rsp_vld=0, busy=0, cmd_rdy=1; LOOKUP any id returns 0.
// 2. NEW a=0; WR_A a=0; WR_B b=0; LOOKUP a=0 -> rsp_data=4, rsp_is_prod=0, err=0.
// 3. NEW 1, NEW 2, WR_A 2, MERGE a=1 b=2; LOOKUP 2 -> 0; LOOKUP 1 -> 5.
//    Acceptance gap after MERGE = 2 cycles.
// 4. Sizes {5,4,2,2,1} in ids 0..4, TOP_K=3, NUM_CONNS=8, UPDATE
//    -> rsp_data=40 exactly 11 cycles after accept, rsp_is_prod=1.
// 5. Single valid net size 3, UPDATE -> 3. No valid nets -> 1. MERGE a=b -> no change, err=0.
// 6. WR_A on invalid id, and a size at 2^SIZE_W-1 plus WR_A -> err=1, size saturated.
//    Hold rsp_rdy=0 for 5 cycles -> rsp_data stable, cmd_rdy=0.

Source files
------------

// File: rtl/ntwrk_size_tracker.sv
// Network-size engine: tracks a live size per network ID, answers single-network
// lookups and reports the product of the TOP_K largest networks on request.
package ntwrk_size_pkg;
    localparam int NTWRK_ID_W = 4;

    typedef enum logic [2:0] {
        CMD_IGNORE = 3'd0,
        CMD_NEW    = 3'd1,
        CMD_WR_A   = 3'd2,
        CMD_WR_B   = 3'd3,
        CMD_MERGE  = 3'd4,
        CMD_LOOKUP = 3'd5,
        CMD_UPDATE = 3'd6,
        CMD_RSVD   = 3'd7
    } ntwrk_cmd_id_e;

    typedef struct packed {
        logic [NTWRK_ID_W-1:0] ntwrkb;
        logic [NTWRK_ID_W-1:0] ntwrka;
        ntwrk_cmd_id_e         id;
    } ntwrk_size_cmd_t;
endpackage

module ntwrk_size_tracker
    import ntwrk_size_pkg::*;
#(
    parameter int NUM_CONNS  = 8,
    parameter int NUM_POINTS = 1000,
    parameter int SIZE_W     = $clog2(NUM_POINTS) + 1,
    parameter int TOP_K      = 3,
    parameter int PROD_W     = SIZE_W * TOP_K
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  ntwrk_size_cmd_t   cmd,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [PROD_W-1:0] rsp_data,
    output logic              rsp_is_prod,
    output logic              busy,
    output logic              err
);
    localparam int IDX_W = (NUM_CONNS > 1) ? $clog2(NUM_CONNS) : 1;
    localparam int K_W   = (TOP_K > 1) ? $clog2(TOP_K) : 1;
    localparam logic [SIZE_W-1:0] SIZE_MAX = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CONNS - 1);
    localparam logic [K_W-1:0]    LAST_K   = K_W'(TOP_K - 1);

    typedef enum logic [2:0] {S_IDLE, S_MERGE, S_SCAN, S_MULT, S_RESP} state_e;
    state_e state_q, state_d;

    logic [SIZE_W-1:0] size_q [NUM_CONNS];
    logic [NUM_CONNS-1:0] valid_q;

    logic [IDX_W-1:0] m_a_q, m_b_q, scan_idx_q;
    logic             m_ok_q;
    logic [SIZE_W-1:0] top_q [TOP_K];
    logic [SIZE_W-1:0] top_d [TOP_K];
    logic [TOP_K-1:0]  fill_q, fill_d, gt;
    logic [K_W-1:0]    k_q;
    logic [PROD_W-1:0] acc_q, factor, mul_next, first_f;
    logic              err_q;

    // Decoded command targets; ids beyond the table are out of range.
    logic             a_in, b_in, w_in;
    logic [IDX_W-1:0] a_idx, b_idx, w_idx;
    logic [SIZE_W:0]  m_sum;
    logic [SIZE_W-1:0] scan_sz;

    assign a_in  = int'(cmd.ntwrka) < NUM_CONNS;
    assign b_in  = int'(cmd.ntwrkb) < NUM_CONNS;
    assign a_idx = IDX_W'(cmd.ntwrka);
    assign b_idx = IDX_W'(cmd.ntwrkb);
    assign w_in  = (cmd.id == CMD_WR_B) ? b_in : a_in;
    assign w_idx = (cmd.id == CMD_WR_B) ? b_idx : a_idx;
    assign m_sum = {1'b0, size_q[m_a_q]} + {1'b0, size_q[m_b_q]};
    assign scan_sz = size_q[scan_idx_q];

    assign cmd_rdy = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign rsp_vld = (state_q == S_RESP);
    assign err     = err_q;

    // Descending insertion; strict compare keeps the earlier entry ahead on ties.
    always_comb begin
        gt = '0;
        for (int k = 0; k < TOP_K; k++) begin
            gt[k]    = !fill_q[k] || (scan_sz > top_q[k]);
            top_d[k] = top_q[k];
        end
        fill_d = fill_q;
        if (valid_q[scan_idx_q] && gt[0]) begin
            top_d[0]  = scan_sz;
            fill_d[0] = 1'b1;
        end
        for (int k = 1; k < TOP_K; k++) begin
            if (valid_q[scan_idx_q] && gt[k]) begin
                if (!gt[k-1]) begin
                    top_d[k]  = scan_sz;
                    fill_d[k] = 1'b1;
                end else begin
                    top_d[k]  = top_q[k-1];
                    fill_d[k] = fill_q[k-1];
                end
            end
        end
    end

    assign first_f  = fill_d[0] ? PROD_W'(top_d[0]) : PROD_W'(1);
    assign factor   = fill_q[k_q] ? PROD_W'(top_q[k_q]) : PROD_W'(1);
    assign mul_next = acc_q * factor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_vld) begin
                    case (cmd.id)
                        CMD_MERGE:  if (cmd.ntwrka != cmd.ntwrkb) state_d = S_MERGE;
                        CMD_LOOKUP: state_d = S_RESP;
                        CMD_UPDATE: state_d = S_SCAN;
                        default:    state_d = S_IDLE;
                    endcase
                end
            end
            S_MERGE: state_d = S_IDLE;
            S_SCAN:  if (scan_idx_q == LAST_IDX) state_d = (TOP_K == 1) ? S_RESP : S_MULT;
            S_MULT:  if (k_q == LAST_K) state_d = S_RESP;
            S_RESP:  if (rsp_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONNS; i++) size_q[i] <= '0;
            for (int k = 0; k < TOP_K; k++) top_q[k] <= '0;
            valid_q     <= '0;
            fill_q      <= '0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            m_ok_q      <= 1'b0;
            scan_idx_q  <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            rsp_data    <= '0;
            rsp_is_prod <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_vld) begin
                        case (cmd.id)
                            CMD_NEW: begin
                                if (a_in) begin
                                    size_q[a_idx]  <= SIZE_W'(2);
                                    valid_q[a_idx] <= 1'b1;
                                    if (valid_q[a_idx]) err_q <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            CMD_WR_A, CMD_WR_B: begin
                                if (w_in && valid_q[w_idx]) begin
                                    if (size_q[w_idx] == SIZE_MAX) err_q <= 1'b1;
                                    else size_q[w_idx] <= size_q[w_idx] + 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            CMD_MERGE: begin
                                m_a_q  <= a_idx;
                                m_b_q  <= b_idx;
                                m_ok_q <= a_in && b_in;
                            end
                            CMD_LOOKUP: begin
                                rsp_data    <= (a_in && valid_q[a_idx]) ? PROD_W'(size_q[a_idx]) : '0;
                                rsp_is_prod <= 1'b0;
                            end
                            CMD_UPDATE: begin
                                scan_idx_q <= '0;
                                fill_q     <= '0;
                            end
                            CMD_RSVD: err_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_MERGE: begin
                    if (m_ok_q && valid_q[m_a_q] && valid_q[m_b_q]) begin
                        if (m_sum[SIZE_W]) begin
                            size_q[m_a_q] <= SIZE_MAX;
                            err_q         <= 1'b1;
                        end else begin
                            size_q[m_a_q] <= m_sum[SIZE_W-1:0];
                        end
                        size_q[m_b_q]  <= '0;
                        valid_q[m_b_q] <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    top_q      <= top_d;
                    fill_q     <= fill_d;
                    scan_idx_q <= scan_idx_q + 1'b1;
                    // Slot 0 is folded in as the list settles, leaving TOP_K-1 multiplies.
                    if (scan_idx_q == LAST_IDX) begin
                        acc_q <= first_f;
                        k_q   <= K_W'(1);
                        if (TOP_K == 1) begin
                            rsp_data    <= first_f;
                            rsp_is_prod <= 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    acc_q <= mul_next;
                    k_q   <= k_q + 1'b1;
                    if (k_q == LAST_K) begin
                        rsp_data    <= mul_next;
                        rsp_is_prod <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ntwrk_size_tracker.sv
// Scoreboarded bench for ntwrk_size_tracker: directed scenarios plus random
// commands checked against a table-and-sort reference model.
module tb_ntwrk_size_tracker;
    import ntwrk_size_pkg::*;

    localparam int NUM_CONNS  = 8;
    localparam int NUM_POINTS = 8;
    localparam int SIZE_W     = 4;
    localparam int TOP_K      = 3;
    localparam int PROD_W     = 12;
    localparam int SIZE_MAX   = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_vld = 1'b0;
    logic cmd_rdy;
    ntwrk_size_cmd_t cmd = '0;
    logic rsp_vld;
    logic rsp_rdy = 1'b0;
    logic [PROD_W-1:0] rsp_data;
    logic rsp_is_prod;
    logic busy;
    logic err;

    ntwrk_size_tracker #(
        .NUM_CONNS(NUM_CONNS), .NUM_POINTS(NUM_POINTS), .SIZE_W(SIZE_W),
        .TOP_K(TOP_K), .PROD_W(PROD_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .rsp_is_prod(rsp_is_prod), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [PROD_W:0] exp_q[$];
    int lat_acc_q[$];
    int lat_exp_q[$];
    logic [PROD_W:0] held;
    bit in_resp = 0;
    bit hold_rdy = 0;
    int last_acc = 0;

    int m_size[NUM_CONNS];
    bit m_valid[NUM_CONNS];
    bit m_err;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CONNS; i++) begin
            m_size[i]  = 0;
            m_valid[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_apply(input ntwrk_cmd_id_e id, input int a, input int b,
                               output bit has_rsp, output logic [PROD_W:0] rsp);
        int t;
        int s;
        int q[$];
        int prod;
        has_rsp = 0;
        rsp = '0;
        case (id)
            CMD_NEW: begin
                if (a < NUM_CONNS) begin
                    if (m_valid[a]) m_err = 1;
                    m_size[a] = 2;
                    m_valid[a] = 1;
                end else m_err = 1;
            end
            CMD_WR_A, CMD_WR_B: begin
                t = (id == CMD_WR_A) ? a : b;
                if (t < NUM_CONNS && m_valid[t]) begin
                    if (m_size[t] == SIZE_MAX) m_err = 1;
                    else m_size[t]++;
                end else m_err = 1;
            end
            CMD_MERGE: begin
                if (a != b) begin
                    if (a < NUM_CONNS && b < NUM_CONNS && m_valid[a] && m_valid[b]) begin
                        s = m_size[a] + m_size[b];
                        if (s > SIZE_MAX) begin
                            s = SIZE_MAX;
                            m_err = 1;
                        end
                        m_size[a] = s;
                        m_size[b] = 0;
                        m_valid[b] = 0;
                    end else m_err = 1;
                end
            end
            CMD_LOOKUP: begin
                has_rsp = 1;
                s = (a < NUM_CONNS && m_valid[a]) ? m_size[a] : 0;
                rsp = {1'b0, PROD_W'(s)};
            end
            CMD_UPDATE: begin
                has_rsp = 1;
                for (int i = 0; i < NUM_CONNS; i++) if (m_valid[i]) q.push_back(m_size[i]);
                q.rsort();
                prod = 1;
                for (int k = 0; k < TOP_K; k++) if (k < q.size()) prod = prod * q[k];
                rsp = {1'b1, PROD_W'(prod)};
            end
            CMD_RSVD: m_err = 1;
            default: ;
        endcase
    endtask

    // Called just after a falling edge; returns one falling edge after acceptance.
    task automatic send(input ntwrk_cmd_id_e id, input int a, input int b);
        int w;
        bit has_rsp;
        logic [PROD_W:0] rsp;
        w = 0;
        while (!cmd_rdy && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_rdy) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept_timeout: cmd_rdy=%0d required 1", cmd_rdy);
            return;
        end
        model_apply(id, a, b, has_rsp, rsp);
        if (has_rsp) begin
            exp_q.push_back(rsp);
            lat_acc_q.push_back(cyc);
            lat_exp_q.push_back((id == CMD_UPDATE) ? NUM_CONNS + TOP_K : 1);
        end
        cmd.id     = id;
        cmd.ntwrka = NTWRK_ID_W'(a);
        cmd.ntwrkb = NTWRK_ID_W'(b);
        cmd_vld    = 1'b1;
        last_acc   = cyc;
        @(negedge clk);
        cmd_vld    = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((busy || exp_q.size() != 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (busy || exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: busy=%0d pending=%0d required 0", busy, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        exp_q.delete();
        lat_acc_q.delete();
        lat_exp_q.delete();
        in_resp = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: drives rsp_rdy for the next edge, then checks what the DUT presents.
    always @(negedge clk) begin
        rsp_rdy = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (!rst && rsp_vld) begin
            if (!in_resp) begin
                in_resp = 1;
                held = {rsp_is_prod, rsp_data};
                if (lat_acc_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got data %0d with nothing pending", rsp_data);
                end else begin
                    check("rsp_latency", cyc - lat_acc_q.pop_front(), lat_exp_q.pop_front());
                end
            end else begin
                check("rsp_hold", int'({rsp_is_prod, rsp_data}), int'(held));
                check("cmd_rdy_in_resp", int'(cmd_rdy), 0);
            end
            if (rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got data %0d with no expectation", rsp_data);
                end else begin
                    check("rsp_data", int'({rsp_is_prod, rsp_data}), int'(exp_q.pop_front()));
                end
                in_resp = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_merge;
        int code;
        int a;
        int b;
        ntwrk_cmd_id_e id;

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rsp_vld", int'(rsp_vld), 0);
        check("reset_cmd_rdy", int'(cmd_rdy), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_rsp_is_prod", int'(rsp_is_prod), 0);
        @(negedge clk);

        // Reset while an UPDATE is scanning.
        send(CMD_NEW, 2, 0);
        send(CMD_UPDATE, 0, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        lat_acc_q.delete();
        lat_exp_q.delete();
        in_resp = 0;
        model_reset();
        @(posedge clk);
        #1;
        check("midscan_rst_rsp_vld", int'(rsp_vld), 0);
        check("midscan_rst_busy", int'(busy), 0);
        check("midscan_rst_cmd_rdy", int'(cmd_rdy), 1);
        @(negedge clk);
        rst = 1'b0;
        send(CMD_LOOKUP, 2, 0);
        send(CMD_LOOKUP, 7, 0);
        drain();

        // NEW then increments from both sides.
        do_reset();
        send(CMD_NEW, 0, 0);
        send(CMD_WR_A, 0, 0);
        send(CMD_WR_B, 0, 0);
        send(CMD_LOOKUP, 0, 0);
        drain();
        check("err_after_basic", int'(err), int'(m_err));

        // MERGE and its two-cycle occupancy.
        do_reset();
        send(CMD_NEW, 1, 0);
        send(CMD_NEW, 2, 0);
        send(CMD_WR_A, 2, 0);
        send(CMD_MERGE, 1, 2);
        c_merge = last_acc;
        send(CMD_LOOKUP, 2, 0);
        check("merge_accept_gap", last_acc - c_merge, 2);
        send(CMD_LOOKUP, 1, 0);
        drain();
        check("err_after_merge", int'(err), int'(m_err));

        // Top-3 product with ties.
        do_reset();
        for (int i = 0; i < 5; i++) send(CMD_NEW, i, 0);
        repeat (3) send(CMD_WR_A, 0, 0);
        repeat (2) send(CMD_WR_B, 0, 1);
        send(CMD_UPDATE, 0, 0);
        drain();

        // Fewer than TOP_K networks, none at all, and self-merge.
        do_reset();
        send(CMD_NEW, 3, 0);
        send(CMD_WR_A, 3, 0);
        send(CMD_UPDATE, 0, 0);
        drain();
        do_reset();
        send(CMD_UPDATE, 0, 0);
        send(CMD_NEW, 5, 0);
        send(CMD_MERGE, 5, 5);
        send(CMD_LOOKUP, 5, 0);
        drain();
        check("err_after_self_merge", int'(err), int'(m_err));

        // Error on invalid target.
        do_reset();
        send(CMD_WR_A, 5, 0);
        drain();
        check("err_invalid_wr", int'(err), int'(m_err));

        // Saturation, then a held response.
        do_reset();
        send(CMD_NEW, 1, 0);
        repeat (15) send(CMD_WR_A, 1, 0);
        drain();
        check("err_saturate", int'(err), int'(m_err));
        hold_rdy = 1;
        @(negedge clk);
        send(CMD_LOOKUP, 1, 0);
        repeat (6) @(negedge clk);
        hold_rdy = 0;
        drain();

        // Randomized commands.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            code = $urandom_range(0, 99);
            if (code < 22)      id = CMD_NEW;
            else if (code < 42) id = CMD_WR_A;
            else if (code < 55) id = CMD_WR_B;
            else if (code < 70) id = CMD_MERGE;
            else if (code < 82) id = CMD_LOOKUP;
            else if (code < 90) id = CMD_UPDATE;
            else if (code < 96) id = CMD_IGNORE;
            else                id = CMD_RSVD;
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            b = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            send(id, a, b);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            if (n % 30 == 29) begin
                drain();
                check("err_random", int'(err), int'(m_err));
            end
            if (n == 149) begin
                do_reset();
                check("err_after_rst", int'(err), 0);
            end
        end
        drain();
        check("err_final", int'(err), int'(m_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
